// File: rtl/serial_adder_n_if.sv
// Handshake and operand/result bundle for serial_adder_n.
// Defining SERIAL_ADDER_SUB_EN adds the sub request line.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle ripple adder: one DIGIT-wide slice plus a carry flop, LSB digit first.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_n_if.slave  bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             c_out_reg;
    logic             ovf_reg;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_s;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             last_digit;

    // Subtraction is folded into capture: store ~b and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1   : bus.c_in;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.c_in;
`endif

    assign last_digit = (cnt_reg == CNT_W'(NDIG - 1));

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                dig_a = a_reg[i*DIGIT +: DIGIT];
                dig_b = b_reg[i*DIGIT +: DIGIT];
            end
        end
    end

    // One DIGIT-wide ripple slice; chain[DIGIT-1] is the carry into the digit MSB.
    assign chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
            assign dig_s[gi]     = dig_a[gi] ^ dig_b[gi] ^ chain[gi];
            assign chain[gi + 1] = (dig_a[gi] & dig_b[gi]) | (chain[gi] & (dig_a[gi] ^ dig_b[gi]));
        end
    endgenerate

    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                sum_next[i*DIGIT +: DIGIT] = dig_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= b_load;
                        carry_reg <= carry_load;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        c_out_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chain[DIGIT];
                    if (last_digit) begin
                        c_out_reg <= chain[DIGIT];
                        ovf_reg   <= chain[DIGIT] ^ chain[DIGIT-1];
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_reg == ST_RUN);
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.sum      = sum_reg;
    assign bus.c_out    = c_out_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: 8/1, 2/1 and 8/4 configurations.
// Subtract checks are compiled in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_n;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_adder_n_if #(.WIDTH(8)) bus8();
    serial_adder_n_if #(.WIDTH(2)) bus2();
    serial_adder_n_if #(.WIDTH(8)) bus84();

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_n #(.WIDTH(2), .DIGIT(1)) u2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst_n(rst_n), .bus(bus84));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse on the 8-bit/1-digit unit, then scrambles the operands.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus8.a = a; bus8.b = b; bus8.c_in = cin; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = ~a; bus8.b = ~b; bus8.c_in = ~cin;
    endtask

    // Counts edges until done on the selected unit, giving up after 20.
    task automatic wait_done(input int which, output int n);
        logic d;
        n = 0;
        d = (which == 0) ? bus8.done : (which == 1) ? bus2.done : bus84.done;
        while (!d && n < 20) begin
            tick();
            n++;
            d = (which == 0) ? bus8.done : (which == 1) ? bus2.done : bus84.done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.c_out, bus8.overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bus8.busy, bus8.done, bus8.c_out, bus8.overflow});
        end
        checks++;
        if (bus8.sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_sum: got %h expected 00", bus8.sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset: busy=%b done=%b sum=%h", bus8.busy, bus8.done, bus8.sum);
    endtask

    task automatic test_zero();
        int n;
        start8(8'h00, 8'h00, 1'b0);
        checks++;
        if ({bus8.busy, bus8.done} !== 2'b10) begin
            errors++;
            $display("FAIL zero_busy: got busy/done=%b expected 10", {bus8.busy, bus8.done});
        end
        wait_done(0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 8", n);
        end
        checks++;
        if ({bus8.c_out, bus8.overflow, bus8.sum} !== 10'h000) begin
            errors++;
            $display("FAIL zero_result: got c=%b v=%b sum=%h expected c=0 v=0 sum=00", bus8.c_out, bus8.overflow, bus8.sum);
        end
        repeat (3) tick();
        checks++;
        if ({bus8.done, bus8.busy, bus8.sum} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL zero_hold: got done=%b busy=%b sum=%h expected 1 0 00", bus8.done, bus8.busy, bus8.sum);
        end
        $display("zero: 00+00+0 -> sum=%h c=%b v=%b latency=%0d", bus8.sum, bus8.c_out, bus8.overflow, n);
    endtask

    task automatic test_back_to_back();
        int n;
        start8(8'hFF, 8'h01, 1'b0);
        wait_done(0, n);
        checks++;
        if (n !== 8 || {bus8.c_out, bus8.overflow, bus8.sum} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL wrap: got n=%0d c=%b v=%b sum=%h expected n=8 c=1 v=0 sum=00", n, bus8.c_out, bus8.overflow, bus8.sum);
        end
        $display("wrap: FF+01+0 -> sum=%h c=%b v=%b latency=%0d", bus8.sum, bus8.c_out, bus8.overflow, n);
        start8(8'h7F, 8'h00, 1'b1);
        checks++;
        if ({bus8.busy, bus8.done, bus8.c_out, bus8.sum} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL b2b_clear: got busy=%b done=%b c=%b sum=%h expected 1 0 0 00", bus8.busy, bus8.done, bus8.c_out, bus8.sum);
        end
        wait_done(0, n);
        checks++;
        if (n !== 8 || {bus8.c_out, bus8.overflow, bus8.sum} !== {2'b01, 8'h80}) begin
            errors++;
            $display("FAIL b2b_result: got n=%0d c=%b v=%b sum=%h expected n=8 c=0 v=1 sum=80", n, bus8.c_out, bus8.overflow, bus8.sum);
        end
        $display("b2b: 7F+00+1 -> sum=%h c=%b v=%b latency=%0d", bus8.sum, bus8.c_out, bus8.overflow, n);
    endtask

    task automatic test_protocol();
        int n;
        start8(8'h12, 8'h34, 1'b0);
        repeat (2) tick();
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: got busy=%b expected 1", bus8.busy);
        end
        wait_done(0, n);
        checks++;
        if (n + 3 !== 8 || bus8.sum !== 8'h46 || bus8.c_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got n=%0d sum=%h c=%b expected n=8 sum=46 c=0", n + 3, bus8.sum, bus8.c_out);
        end
        $display("protocol: 12+34 with start at cycle 3 -> sum=%h latency=%0d", bus8.sum, n + 3);
    endtask

    task automatic test_reset_mid_run();
        int n;
        start8(8'h12, 8'h34, 1'b0);
        repeat (4) tick();
        checks++;
        if (bus8.sum !== 8'h06) begin
            errors++;
            $display("FAIL partial_sum: got %h expected 06", bus8.sum);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum} !== 10'h000) begin
            errors++;
            $display("FAIL abort: got busy=%b done=%b sum=%h expected 0 0 00", bus8.busy, bus8.done, bus8.sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start8(8'h0F, 8'h01, 1'b0);
        wait_done(0, n);
        checks++;
        if (n !== 8 || bus8.sum !== 8'h10 || bus8.c_out !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got n=%0d sum=%h c=%b expected n=8 sum=10 c=0", n, bus8.sum, bus8.c_out);
        end
        $display("reset_mid_run: 0F+01 after abort -> sum=%h latency=%0d", bus8.sum, n);
    endtask

    task automatic test_sweep_w2();
        int n;
        logic [2:0] exp_total;
        logic       exp_v;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [1:0] va;
                    logic [1:0] vb;
                    va = 2'(ia);
                    vb = 2'(ib);
                    exp_total = 3'(ia + ib + ic);
                    exp_v = (va[1] == vb[1]) && (exp_total[1] != va[1]);
                    bus2.a = va; bus2.b = vb; bus2.c_in = ic[0]; bus2.start = 1'b1;
                    tick();
                    bus2.start = 1'b0;
                    wait_done(1, n);
                    checks++;
                    if (n !== 2 || {bus2.c_out, bus2.sum} !== exp_total || bus2.overflow !== exp_v) begin
                        errors++;
                        $display("FAIL sweep_w2: a=%0d b=%0d c=%0d got n=%0d total=%0d v=%b expected n=2 total=%0d v=%b",
                                 ia, ib, ic, n, {bus2.c_out, bus2.sum}, bus2.overflow, exp_total, exp_v);
                    end
                    $display("sweep_w2: %0d+%0d+%0d -> total=%0d v=%b", ia, ib, ic, {bus2.c_out, bus2.sum}, bus2.overflow);
                end
            end
        end
    endtask

    task automatic test_digit4();
        int n;
        bus84.a = 8'h9C; bus84.b = 8'h75; bus84.c_in = 1'b1; bus84.start = 1'b1;
        tick();
        bus84.start = 1'b0;
        bus84.a = 8'h00; bus84.b = 8'h00; bus84.c_in = 1'b0;
        wait_done(2, n);
        checks++;
        if (n !== 2 || {bus84.c_out, bus84.overflow, bus84.sum} !== {2'b10, 8'h12}) begin
            errors++;
            $display("FAIL digit4: got n=%0d c=%b v=%b sum=%h expected n=2 c=1 v=0 sum=12", n, bus84.c_out, bus84.overflow, bus84.sum);
        end
        $display("digit4: 9C+75+1 -> sum=%h c=%b v=%b latency=%0d", bus84.sum, bus84.c_out, bus84.overflow, n);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int n;
        bus8.sub = 1'b1;
        start8(8'h05, 8'h07, 1'b0);
        bus8.sub = 1'b0;
        wait_done(0, n);
        checks++;
        if (n !== 8 || {bus8.c_out, bus8.overflow, bus8.sum} !== {2'b00, 8'hFE}) begin
            errors++;
            $display("FAIL sub_borrow: got n=%0d c=%b v=%b sum=%h expected n=8 c=0 v=0 sum=FE", n, bus8.c_out, bus8.overflow, bus8.sum);
        end
        $display("sub: 05-07 -> sum=%h c=%b v=%b", bus8.sum, bus8.c_out, bus8.overflow);
        bus8.sub = 1'b1;
        start8(8'h80, 8'h01, 1'b0);
        bus8.sub = 1'b0;
        wait_done(0, n);
        checks++;
        if (n !== 8 || {bus8.c_out, bus8.overflow, bus8.sum} !== {2'b11, 8'h7F}) begin
            errors++;
            $display("FAIL sub_overflow: got n=%0d c=%b v=%b sum=%h expected n=8 c=1 v=1 sum=7F", n, bus8.c_out, bus8.overflow, bus8.sum);
        end
        $display("sub: 80-01 -> sum=%h c=%b v=%b", bus8.sum, bus8.c_out, bus8.overflow);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.c_in = 1'b0;
        bus2.start = 1'b0;  bus2.a = '0;  bus2.b = '0;  bus2.c_in = 1'b0;
        bus84.start = 1'b0; bus84.a = '0; bus84.b = '0; bus84.c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b0; bus2.sub = 1'b0; bus84.sub = 1'b0;
`endif
        repeat (2) tick();
        test_reset();
        test_zero();
        test_back_to_back();
        test_protocol();
        test_reset_mid_run();
        test_sweep_w2();
        test_digit4();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle ripple adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- One DIGIT-wide full-adder slice plus a carry flip-flop replaces a WIDTH-wide combinational chain.
- start/busy/done handshake; result registered and held until the next accepted start.
- Serves as the sequential successor of the lab full-adder cell and as the arithmetic unit for later datapath practicals.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- Derived NDIG = WIDTH/DIGIT: number of digit cycles.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled on clk; accepted only in IDLE or DONE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- c_in  in  1  carry-in; captured when start is accepted.
- busy  out  1  high while digits are being processed.
- done  out  1  high while sum, c_out and overflow are valid.
- sum  out  WIDTH  result, a + b + c_in modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB.
- overflow  out  1  two's-complement overflow: carry into the MSB XOR c_out.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, c_out = 0, overflow = 0.
  - Internal operand registers, carry FF and digit counter = 0.
- States:
  - IDLE: waits for start.
  - RUN: processes one digit per cycle.
  - DONE: holds the result.
- IDLE/DONE with start = 1 at edge k:
  - Capture a, b, c_in; carry FF = c_in; counter = 0.
  - sum, c_out and overflow are cleared to 0.
  - Next state RUN: busy = 1, done = 0 after edge k.
- RUN, each edge:
  - Digit i = counter: {carry, s} = a[i] + b[i] + carry_ff (DIGIT-bit add).
  - s is written into sum bits [i*DIGIT +: DIGIT]; the carry FF is updated; counter increments.
  - For the last digit (counter = NDIG-1): the carry into bit WIDTH-1 is computed inside the slice; overflow = that carry XOR the final carry; c_out = final carry.
- After the last digit (edge k+NDIG): state DONE, busy = 0, done = 1.
  - Latency from accepted start to done = NDIG cycles (8 for the defaults).
- DONE: sum, c_out, overflow and done stay stable until the next accepted start or reset.
  - start in DONE behaves as in IDLE: back-to-back operation with no idle cycle.
- start while busy = 1 is ignored. Operands are not recaptured and the latency is unchanged.
- a, b and c_in may change freely after capture without affecting the result.
- Reset mid-RUN: the operation is aborted and all outputs return to reset values in the same cycle.
  - The first start after rst_n rises is accepted normally.
- DIGIT = WIDTH: NDIG = 1, so done appears one cycle after start.
- The counter width is ceil(log2(NDIG)) with a minimum of 1. It never wraps while in RUN.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured together with the operands.
  - sub = 1 computes a + ~b + 1. c_in is ignored and the initial carry is forced to 1.
  - c_out = 1 means no borrow. overflow is the signed subtraction overflow.
  - sub = 0 behaves exactly as the base block.
- When undefined: no sub port; logic is identical to the base description.

Test Plan:
- Defaults (WIDTH=8, DIGIT=1), a=8'h00, b=8'h00, c_in=0, start pulse -> busy for 8 cycles, then done=1, sum=8'h00, c_out=0, overflow=0.
- a=8'hFF, b=8'h01, c_in=0 -> done after 8 cycles; sum=8'h00, c_out=1, overflow=0. Then a=8'h7F, b=8'h00, c_in=1 with start in DONE -> sum=8'h80, c_out=0, overflow=1.
- Exhaustive sweep, WIDTH=2, DIGIT=1: all 32 combinations of a, b, c_in -> {c_out, sum} equals a+b+c_in every time; done exactly 2 cycles after each start.
- Protocol: start with a=8'h12, b=8'h34; pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> second request ignored; result sum=8'h46 after 8 cycles.
- Reset: assert rst_n=0 at RUN cycle 4 -> busy, done and sum drop to 0 immediately. Release, then start with 8'h0F+8'h01 -> sum=8'h10.
- WIDTH=8, DIGIT=4: a=8'h9C, b=8'h75, c_in=1 -> done 2 cycles after start; sum=8'h12, c_out=1, overflow=0.
- With SERIAL_ADDER_SUB_EN defined: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, c_out=0. Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, overflow=1.
